multicycle_controller: RTL and testbench

//  FSM that sequences the shared RV32I datapath over multiple cycles (fetch, decode, execute, memory, writeback).
//  One unified memory port, with a req/ready handshake, serves both instruction fetch and data access.

---
 rtl/multicycle_controller_if.sv | 23 ++
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Unified memory port between the multicycle controller and memory: request, direction, address select, ready.
// Latency: pure wiring. Backpressure: mem_req is held until memory answers with a one-cycle mem_ready pulse.
// Controller side uses the master modport; memory (or a bench) uses slave.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_is_fetch;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_is_fetch,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_is_fetch,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALTED); optional counters behind PERF_CNT_EN.
// Latency: zero-wait memory gives R/I/LUI/store 4, load 5, branch/JAL/JALR 3 cycles; outputs are Moore except ir_write/pc_write.
// Backpressure: stalls in FETCH/MEM until mem_ready; MEM_TIMEOUT waiting cycles without it halts with a bus error.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_controller_if.master bus,
    input  logic [6:0]             opcode,
    input  logic                   branch_taken,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic [1:0]             pc_src,
    output logic                   reg_write,
    output logic [1:0]             wb_sel,
    output logic                   alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   halt,
    output logic [1:0]             error,
    output logic [2:0]             state_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instret_cnt
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("multicycle_controller: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [6:0]        op_q;
    logic [1:0]        error_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;
    logic              mem_req_c;
    logic              mem_we_c;
    logic              mem_is_fetch_c;

    // The limit cycle is the MEM_TIMEOUT-th waiting cycle; a mem_ready in it still completes the access.
    assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        error_nxt = error;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (wait_last) begin
                    state_nxt = S_HALTED;
                    error_nxt = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT: state_nxt = S_HALTED;
                    OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_B, OP_JAL, OP_JALR:
                        state_nxt = S_EXEC;
                    default: begin
                        state_nxt = S_HALTED;
                        error_nxt = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOAD, OP_STORE:     state_nxt = S_MEM;
                    OP_B, OP_JAL, OP_JALR: state_nxt = S_FETCH;
                    default:               state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_nxt = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (wait_last) begin
                    state_nxt = S_HALTED;
                    error_nxt = ERR_TIMEOUT;
                end
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_is_fetch_c = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 2'b00;
        reg_write      = 1'b0;
        wb_sel         = 2'b00;
        alu_src_b      = 1'b0;
        alu_op         = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req_c      = 1'b1;
                mem_is_fetch_c = 1'b1;
                ir_write       = bus.mem_ready;
                pc_write       = bus.mem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: alu_op = 2'b10;
                    OP_I: begin
                        alu_op    = 2'b10;
                        alu_src_b = 1'b1;
                    end
                    OP_LUI, OP_LOAD, OP_STORE: alu_src_b = 1'b1;
                    OP_B: begin
                        alu_op   = 2'b01;
                        pc_src   = 2'b01;
                        pc_write = branch_taken;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b01;
                    end
                    OP_JALR: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (op_q == OP_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    // Request is decoded from state alone, so an asynchronous reset drops it immediately.
    assign bus.mem_req      = mem_req_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.mem_is_fetch = mem_is_fetch_c;
    assign halt             = (state == S_HALTED);
    assign state_o          = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            op_q     <= 7'd0;
            error    <= ERR_NONE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            error <= error_nxt;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            if (state_nxt != state && (state_nxt == S_FETCH || state_nxt == S_MEM)) begin
                wait_cnt <= '0;
            end else if (mem_req_c && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic retire;

    assign retire = (state == S_EXEC || state == S_MEM || state == S_WB) && (state_nxt == S_FETCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_HALTED) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (retire) begin
                instret_cnt <= instret_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4); counter checks only when PERF_CNT_EN is defined.
module tb_multicycle_controller;
    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       ir_write, pc_write, reg_write, alu_src_b, halt;
    logic [1:0] pc_src, wb_sel, alu_op, error;
    logic [2:0] state_o;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int errors = 0;
    int checks = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.master),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .halt         (halt),
        .error        (error),
        .state_o      (state_o)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch of op: leaves the FSM in DECODE.
    task automatic do_fetch(input logic [6:0] op);
        opcode = op;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        bus.mem_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        opcode = 7'd0;
        branch_taken = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state: FETCH Moore outputs only
        chk("rst_state", state_o, 0);
        chk("rst_req", bus.mem_req, 1);
        chk("rst_fetch", bus.mem_is_fetch, 1);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_halt", halt, 0);
        chk("rst_err", error, 0);
        chk("rst_regw", reg_write, 0);
        chk("rst_irw", ir_write, 0);
`ifdef PERF_CNT_EN
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_inst", instret_cnt, 0);
`endif

        // R-type, zero-wait fetch: 0,1,2,4,0; opcode input changed after DECODE to prove it is latched
        opcode = 7'b0110011;
        bus.mem_ready = 1'b1;
        #1;
        chk("r_irw", ir_write, 1);
        chk("r_pcw", pc_write, 1);
        chk("r_pcsrc", pc_src, 0);
        tick();
        bus.mem_ready = 1'b0;
        chk("r_dec", state_o, 1);
        chk("r_dec_req", bus.mem_req, 0);
        tick();
        opcode = 7'b0000000;
        #1;
        chk("r_exec", state_o, 2);
        chk("r_aluop", alu_op, 2);
        chk("r_srcb", alu_src_b, 0);
        tick();
        chk("r_wb", state_o, 4);
        chk("r_wb_regw", reg_write, 1);
        chk("r_wb_sel", wb_sel, 0);
        tick();
        chk("r_done", state_o, 0);

        // LOAD with mem_ready after 3 wait cycles in MEM: 8 cycles total
        do_fetch(7'b0000011);
        tick();
        chk("ld_exec_aluop", alu_op, 0);
        chk("ld_exec_srcb", alu_src_b, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ld_mem_state", state_o, 3);
            chk("ld_mem_req", bus.mem_req, 1);
            chk("ld_mem_we", bus.mem_we, 0);
            chk("ld_mem_fetch", bus.mem_is_fetch, 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("ld_mem_req4", bus.mem_req, 1);
        chk("ld_mem_irw", ir_write, 0);
        tick();
        bus.mem_ready = 1'b0;
        chk("ld_wb", state_o, 4);
        chk("ld_wb_sel", wb_sel, 1);
        chk("ld_wb_regw", reg_write, 1);
        tick();
        chk("ld_done", state_o, 0);

        // Branch: pc_write follows branch_taken in EXEC, back to FETCH
        do_fetch(7'b1100011);
        tick();
        branch_taken = 1'b1;
        #1;
        chk("b_t_pcw", pc_write, 1);
        chk("b_t_pcsrc", pc_src, 1);
        chk("b_aluop", alu_op, 1);
        branch_taken = 1'b0;
        #1;
        chk("b_nt_pcw", pc_write, 0);
        tick();
        chk("b_done", state_o, 0);

        // JAL and JALR: link write in EXEC, 3 cycles
        do_fetch(7'b1101111);
        tick();
        chk("jal_regw", reg_write, 1);
        chk("jal_wbsel", wb_sel, 2);
        chk("jal_pcw", pc_write, 1);
        chk("jal_pcsrc", pc_src, 1);
        tick();
        chk("jal_done", state_o, 0);
        do_fetch(7'b1100111);
        tick();
        chk("jalr_pcsrc", pc_src, 2);
        chk("jalr_srcb", alu_src_b, 1);
        chk("jalr_regw", reg_write, 1);
        tick();
        chk("jalr_done", state_o, 0);

        // STORE, zero-wait data write: 4 cycles, no WB
        do_fetch(7'b0100011);
        tick();
        tick();
        bus.mem_ready = 1'b1;
        #1;
        chk("st_we", bus.mem_we, 1);
        chk("st_req", bus.mem_req, 1);
        tick();
        bus.mem_ready = 1'b0;
        chk("st_done", state_o, 0);

        // I-type
        do_fetch(7'b0010011);
        tick();
        chk("i_aluop", alu_op, 2);
        chk("i_srcb", alu_src_b, 1);
        tick();
        chk("i_wb", state_o, 4);
        tick();

        // Fetch ready on the 4th (limit) waiting cycle still completes; LUI follows
        tick();
        tick();
        tick();
        chk("tw_wait", state_o, 0);
        opcode = 7'b0110111;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("tw_dec", state_o, 1);
        chk("tw_err", error, 0);
        tick();
        chk("lui_aluop", alu_op, 0);
        chk("lui_srcb", alu_src_b, 1);
        tick();
        tick();
        chk("lui_done", state_o, 0);

        // Fetch timeout: 4 cycles without mem_ready -> HALTED, error=10
        tick();
        tick();
        tick();
        chk("to_req3", bus.mem_req, 1);
        tick();
        chk("to_state", state_o, 5);
        chk("to_err", error, 2);
        chk("to_halt", halt, 1);
        chk("to_req", bus.mem_req, 0);

        // HALT opcode; later mem_ready pulses change nothing
        do_reset();
        chk("rr_err", error, 0);
        chk("rr_halt", halt, 0);
        do_fetch(7'b1111111);
        tick();
        chk("h_state", state_o, 5);
        chk("h_halt", halt, 1);
        chk("h_err", error, 0);
        bus.mem_ready = 1'b1;
        #1;
        chk("h_irw", ir_write, 0);
        chk("h_pcw", pc_write, 0);
        chk("h_req", bus.mem_req, 0);
        tick();
        bus.mem_ready = 1'b0;
        chk("h_state2", state_o, 5);
        chk("h_regw", reg_write, 0);

        // Illegal opcode
        do_reset();
        do_fetch(7'b0000000);
        tick();
        chk("ill_state", state_o, 5);
        chk("ill_err", error, 1);

        // Reset during the MEM phase of a store
        do_reset();
        do_fetch(7'b0100011);
        tick();
        tick();
        chk("sr_mem", bus.mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("sr_req", bus.mem_req & ~bus.mem_is_fetch, 0);
        chk("sr_state", state_o, 0);
        chk("sr_err", error, 0);
        #1;
        reset_n = 1'b1;

`ifdef PERF_CNT_EN
        chk("pc_cyc0", cycle_cnt, 0);
        chk("pc_inst0", instret_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            do_fetch(7'b0110011);
            tick();
            tick();
            tick();
        end
        chk("pc_inst3", instret_cnt, 3);
        chk("pc_cyc12", cycle_cnt, 12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
